// File: rtl/controladora_multizona.sv
// Multi-zone lighting controller: per-zone debounce, hold timer and AUTO/MANUAL lamp FSM,
// all paced by a shared 1 ms tick derived from clk.

module controladora_zona #(
   parameter int DEBOUNCE_P        = 300,
   parameter int SWITCH_MODE_MIN_T = 5000,
   parameter int AUTO_SHUTDOWN_T   = 30000,
   parameter int WARN_T            = 5000,
   parameter int BLINK_T           = 250
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic btn,
   input  logic ir,
   input  logic all_off,
   output logic saida,
   output logic led
);
   localparam int DBW = $clog2(DEBOUNCE_P + 1);
   localparam int HW  = $clog2(SWITCH_MODE_MIN_T + 1);
   localparam int TW  = $clog2(AUTO_SHUTDOWN_T + 1);
   localparam int BW  = $clog2(BLINK_T + 1);
   localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_P - 1);
   localparam logic [HW-1:0]  HOLD_MAX  = HW'(SWITCH_MODE_MIN_T);
   localparam logic [HW-1:0]  HOLD_LAST = HW'(SWITCH_MODE_MIN_T - 1);
   localparam logic [TW-1:0]  T_MAX     = TW'(AUTO_SHUTDOWN_T);
   localparam logic [TW-1:0]  T_WARN    = TW'(WARN_T);
   localparam logic [BW-1:0]  BL_LAST   = BW'(BLINK_T - 1);

   typedef enum logic [2:0] {AUTO_OFF, AUTO_ON, AUTO_WARN, MAN_OFF, MAN_ON} estado_t;

   estado_t          estado;
   logic             db;
   logic [DBW-1:0]   db_cnt;
   logic [HW-1:0]    hold_cnt;
   logic [TW-1:0]    timer;
   logic [BW-1:0]    blink_cnt;
   logic             fase;
   logic             db_flip, db_fall, short_press, long_press;
   logic [TW-1:0]    timer_dec;
   logic             saida_d, led_d;

   assign db_flip     = tick && (btn != db) && (db_cnt == DB_LAST);
   assign db_fall     = db_flip && db;
   // saturated hold_cnt means the mode already toggled during this press
   assign short_press = db_fall && (hold_cnt != HOLD_MAX);
   assign long_press  = tick && db && !db_fall && (hold_cnt == HOLD_LAST);
   assign timer_dec   = timer - 1'b1;

   always_comb begin
      saida_d = 1'b0;
      led_d   = 1'b0;
      case (estado)
         AUTO_ON:   saida_d = 1'b1;
         AUTO_WARN: saida_d = fase;
         MAN_OFF:   led_d   = 1'b1;
         MAN_ON:    begin saida_d = 1'b1; led_d = 1'b1; end
         default:   saida_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         estado    <= AUTO_OFF;
         db        <= 1'b0;
         db_cnt    <= '0;
         hold_cnt  <= '0;
         timer     <= '0;
         blink_cnt <= '0;
         fase      <= 1'b0;
         saida     <= 1'b0;
         led       <= 1'b0;
      end else begin
         saida <= saida_d;
         led   <= led_d;

         if (tick) begin
            if (btn != db) begin
               if (db_flip) begin
                  db     <= ~db;
                  db_cnt <= '0;
               end else
                  db_cnt <= db_cnt + 1'b1;
            end else
               db_cnt <= '0;

            if (db_fall || !db)
               hold_cnt <= '0;
            else if (hold_cnt != HOLD_MAX)
               hold_cnt <= hold_cnt + 1'b1;
         end

         if (all_off) begin
            case (estado)
               MAN_ON, MAN_OFF: estado <= MAN_OFF;
               default: begin
                  estado <= AUTO_OFF;
                  timer  <= '0;
               end
            endcase
         end else if (tick) begin
            if (long_press) begin
               case (estado)
                  AUTO_ON, AUTO_WARN: estado <= MAN_ON;
                  AUTO_OFF:           estado <= MAN_OFF;
                  default: begin
                     estado <= AUTO_OFF;
                     timer  <= '0;
                  end
               endcase
            end else begin
               case (estado)
                  AUTO_OFF: if (ir) begin
                     estado <= AUTO_ON;
                     timer  <= T_MAX;
                  end
                  AUTO_ON: begin
                     if (ir)
                        timer <= T_MAX;
                     else begin
                        timer <= timer_dec;
                        if (WARN_T > 0 && timer_dec == T_WARN) begin
                           estado    <= AUTO_WARN;
                           blink_cnt <= '0;
                           fase      <= 1'b1;
                        end else if (WARN_T == 0 && timer_dec == '0)
                           estado <= AUTO_OFF;
                     end
                  end
                  AUTO_WARN: begin
                     if (ir) begin
                        estado <= AUTO_ON;
                        timer  <= T_MAX;
                     end else begin
                        timer <= timer_dec;
                        if (timer_dec == '0)
                           estado <= AUTO_OFF;
                     end
                     if (blink_cnt == BL_LAST) begin
                        blink_cnt <= '0;
                        fase      <= ~fase;
                     end else
                        blink_cnt <= blink_cnt + 1'b1;
                  end
                  MAN_OFF: if (short_press) estado <= MAN_ON;
                  MAN_ON:  if (short_press) estado <= MAN_OFF;
                  default: begin
                     estado <= AUTO_OFF;
                     timer  <= '0;
                  end
               endcase
            end
         end
      end
   end
endmodule

module controladora_multizona #(
   parameter int N_ZONES           = 4,
   parameter int CLK_DIV           = 50000,
   parameter int DEBOUNCE_P        = 300,
   parameter int SWITCH_MODE_MIN_T = 5000,
   parameter int AUTO_SHUTDOWN_T   = 30000,
   parameter int WARN_T            = 5000,
   parameter int BLINK_T           = 250
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_ZONES-1:0] push_button,
   input  logic [N_ZONES-1:0] infravermelho,
   input  logic               all_off,
   output logic [N_ZONES-1:0] saida,
   output logic [N_ZONES-1:0] led,
   output logic               tick
);
   localparam int DIVW = $clog2(CLK_DIV);
   localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLK_DIV - 1);

   logic [DIVW-1:0]    div_cnt;
   logic [N_ZONES-1:0] btn_s1, btn_s2, ir_s1, ir_s2;

   assign tick = (div_cnt == DIV_LAST);

   always_ff @(posedge clk) begin
      if (!rst) begin
         div_cnt <= '0;
         btn_s1  <= '0;
         btn_s2  <= '0;
         ir_s1   <= '0;
         ir_s2   <= '0;
      end else begin
         div_cnt <= tick ? '0 : div_cnt + 1'b1;
         btn_s1  <= push_button;
         btn_s2  <= btn_s1;
         ir_s1   <= infravermelho;
         ir_s2   <= ir_s1;
      end
   end

   for (genvar z = 0; z < N_ZONES; z++) begin : g_zona
      controladora_zona #(
         .DEBOUNCE_P       (DEBOUNCE_P),
         .SWITCH_MODE_MIN_T(SWITCH_MODE_MIN_T),
         .AUTO_SHUTDOWN_T  (AUTO_SHUTDOWN_T),
         .WARN_T           (WARN_T),
         .BLINK_T          (BLINK_T)
      ) u_zona (
         .clk    (clk),
         .rst    (rst),
         .tick   (tick),
         .btn    (btn_s2[z]),
         .ir     (ir_s2[z]),
         .all_off(all_off),
         .saida  (saida[z]),
         .led    (led[z])
      );
   end
endmodule

// File: tb/tb_controladora_multizona.sv
// Directed bench: tick-aligned stimulus, each check compares against hand-derived tick counts.

module tb_controladora_multizona;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] pb  = '0;
   logic [3:0] ir  = '0;
   logic       ao  = 1'b0;
   logic [3:0] saida, led;
   logic       tick;
   int         tn = 0;
   int         n_chk = 0;
   int         n_pass = 0;

   controladora_multizona #(
      .N_ZONES(4), .CLK_DIV(4), .DEBOUNCE_P(3), .SWITCH_MODE_MIN_T(20),
      .AUTO_SHUTDOWN_T(40), .WARN_T(10), .BLINK_T(2)
   ) dut (
      .clk(clk), .rst(rst), .push_button(pb), .infravermelho(ir),
      .all_off(ao), .saida(saida), .led(led), .tick(tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (tick %0d)", tag, act, exp, tn);
   endtask

   // stop at the negedge just before the next tick edge
   task automatic to_tick();
      int g = 0;
      do begin
         @(negedge clk);
         g++;
      end while (!tick && g < 16);
      if (!tick) chk("tick_timeout", 32'(tick), 1);
   endtask

   task automatic tk();
      to_tick();
      tn++;
   endtask

   task automatic run_to(input int n);
      while (tn < n) tk();
   endtask

   task automatic align();
      to_tick();
      tn = 0;
   endtask

   initial begin
      // reset with every input asserted
      rst = 1'b0; pb = '1; ir = '1; ao = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("rst_saida", saida, 0);
      chk("rst_led", led, 0);
      chk("rst_tick", tick, 0);
      pb = '0; ir = '0; ao = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      to_tick();
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         chk("tick_period", tick, (i == 4) ? 1 : 0);
      end
      chk("post_rst_saida", saida, 0);

      // zone 0: long press -> MANUAL after exactly 20 ticks of db, no lamp toggle on release
      align(); pb[0] = 1'b1;
      run_to(23); chk("z0_led_before", led[0], 0);
      run_to(24); chk("z0_led_toggle", led[0], 1);
      run_to(30); pb[0] = 1'b0;
      run_to(36);
      chk("z0_release_saida", saida[0], 0);
      chk("z0_release_led", led[0], 1);

      // zone 0: 2-tick glitch is filtered, 3-tick press is a short press
      align(); pb[0] = 1'b1;
      run_to(2); pb[0] = 1'b0;
      run_to(10); chk("z0_glitch", saida[0], 0);
      align(); pb[0] = 1'b1;
      run_to(3); pb[0] = 1'b0;
      run_to(6); chk("z0_short_before", saida[0], 0);
      run_to(7); chk("z0_short_on", saida[0], 1);

      // zone 1: one-tick IR -> 30 ticks solid, 10 ticks blinking, then off
      align(); ir[1] = 1'b1;
      run_to(1); ir[1] = 1'b0;
      for (int k = 1; k <= 42; k++) begin
         int e;
         if (k <= 30)      e = 1;
         else if (k <= 40) e = (((k - 31) / 2) % 2 == 0) ? 1 : 0;
         else              e = 0;
         run_to(k + 1);
         chk("z1_auto_cycle", saida[1], e);
      end
      chk("z1_led", led[1], 0);

      // zone 1: IR during blinking reloads the full timer
      align(); ir[1] = 1'b1;
      run_to(1); ir[1] = 1'b0;
      run_to(33); ir[1] = 1'b1;
      run_to(34); ir[1] = 1'b0;
      chk("z1_warn_phase0", saida[1], 0);
      for (int k = 34; k <= 63; k++) begin
         run_to(k + 1);
         chk("z1_reload_solid", saida[1], 1);
      end
      run_to(65); chk("z1_rewarn_on", saida[1], 1);
      run_to(67); chk("z1_rewarn_off", saida[1], 0);
      run_to(74); chk("z1_rewarn_last", saida[1], 1);
      run_to(75); chk("z1_reoff", saida[1], 0);

      // zone 2: enter MANUAL, short presses toggle, IR ignored
      align(); pb[2] = 1'b1;
      run_to(25); pb[2] = 1'b0;
      run_to(32);
      chk("z2_led", led[2], 1);
      chk("z2_man_off", saida[2], 0);
      align(); pb[2] = 1'b1;
      run_to(5); pb[2] = 1'b0;
      run_to(11); chk("z2_toggle_on", saida[2], 1);
      align(); ir[2] = 1'b1;
      run_to(6); ir[2] = 1'b0;
      run_to(10); chk("z2_ir_ignored_on", saida[2], 1);
      align(); pb[2] = 1'b1;
      run_to(5); pb[2] = 1'b0;
      run_to(11); chk("z2_toggle_off", saida[2], 0);
      align(); ir[2] = 1'b1;
      run_to(6); ir[2] = 1'b0;
      run_to(10); chk("z2_ir_ignored_off", saida[2], 0);

      // zone 3: long press lands in AUTO_WARN -> MAN_ON steady; long press again -> AUTO_OFF
      align(); ir[3] = 1'b1;
      run_to(1); ir[3] = 1'b0;
      run_to(10); pb[3] = 1'b1;
      run_to(33);
      chk("z3_warn_led", led[3], 0);
      chk("z3_warn_saida", saida[3], 1);
      run_to(34);
      chk("z3_man_led", led[3], 1);
      chk("z3_man_steady0", saida[3], 1);
      run_to(35);
      chk("z3_man_steady1", saida[3], 1);
      pb[3] = 1'b0;
      run_to(45);
      chk("z3_after_release", saida[3], 1);
      chk("z3_after_release_led", led[3], 1);
      align(); pb[3] = 1'b1;
      run_to(23);
      chk("z3_back_led_before", led[3], 1);
      run_to(24);
      chk("z3_back_led", led[3], 0);
      chk("z3_back_saida", saida[3], 0);
      run_to(25); pb[3] = 1'b0;
      run_to(32);
      chk("z3_auto_idle", saida[3], 0);

      // all_off with every lamp lit in mixed modes
      align(); ir[1] = 1'b1; ir[3] = 1'b1; pb[2] = 1'b1;
      run_to(1); ir[1] = 1'b0; ir[3] = 1'b0;
      run_to(5); pb[2] = 1'b0;
      run_to(11);
      chk("ao_all_lit", saida, 4'b1111);
      chk("ao_led_before", led, 4'b0101);
      to_tick();
      ao = 1'b1;
      @(negedge clk);
      ao = 1'b0;
      @(negedge clk);
      chk("ao_saida", saida, 4'b0000);
      chk("ao_led_kept", led, 4'b0101);
      align();
      run_to(5);
      chk("ao_stays_off", saida, 4'b0000);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/controladora_multizona.md
# controladora_multizona

Multi-zone automatic lighting controller: N independent zones, each with a push button and an infrared presence sensor, each driving one lamp output and one mode LED. Each zone has AUTO mode (presence-triggered, timed shutdown with a blinking pre-shutdown warning) and MANUAL mode (short press toggles the lamp), and a long press toggles between the two. A global `all_off` command turns every lamp off. All timing derives from an internal 1 ms tick in the single `clk` domain; there is no derived clock.

## Interface
- `N_ZONES`, 4: number of zones (1..16).
- `CLK_DIV`, 50000: `clk` cycles per 1 ms tick (≥2).
- `DEBOUNCE_P`, 300: ticks the raw button must hold a new level before the debounced level changes.
- `SWITCH_MODE_MIN_T`, 5000: held ticks that trigger a mode toggle.
- `AUTO_SHUTDOWN_T`, 30000: AUTO on-time in ticks after the last presence.
- `WARN_T`, 5000: final ticks of the on-time spent blinking; 0 disables the warning; must be < `AUTO_SHUTDOWN_T`.
- `BLINK_T`, 250: half-period of the warning blink in ticks.

- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-low.
- `push_button` in N_ZONES: raw asynchronous buttons, active-high.
- `infravermelho` in N_ZONES: raw asynchronous presence sensors, active-high.
- `all_off` in 1: synchronous global off, sampled every `clk` edge.
- `saida` out N_ZONES: lamp drive, registered.
- `led` out N_ZONES: 1 = zone in MANUAL, registered.
- `tick` out 1: the 1 ms strobe, for observation.

## Operation
- Tick: a divider counts 0..CLK_DIV-1. `tick` is high for exactly one cycle when the count equals CLK_DIV-1, then the count wraps to 0.
- Synchronisers: every `push_button` and `infravermelho` bit passes through two flops before any use.
- Debounce, per zone: counter `db_cnt`. On a tick where the synced button differs from the debounced level `db`, increment `db_cnt`; otherwise clear it. When `db_cnt` reaches DEBOUNCE_P, `db` flips and `db_cnt` clears.
- Hold timer, per zone: `hold_cnt` saturates at SWITCH_MODE_MIN_T and counts ticks while `db`=1.
  - When `hold_cnt` reaches SWITCH_MODE_MIN_T, the mode toggles exactly once per press.
  - On the falling edge of `db` with `hold_cnt` < SWITCH_MODE_MIN_T (a short press): in MANUAL the lamp toggles; in AUTO nothing happens.
  - `hold_cnt` clears on release.
- Zone FSM, evaluated on ticks; `timer` is sized $clog2(AUTO_SHUTDOWN_T+1):
  - AUTO_OFF: `saida`=0. Synced IR=1 → AUTO_ON, `timer`=AUTO_SHUTDOWN_T.
  - AUTO_ON: `saida`=1. IR=1 reloads `timer`; otherwise `timer` decrements.
    - `timer`==WARN_T with WARN_T>0 → AUTO_WARN, blink counter cleared, blink phase=1.
    - `timer` reaching 0 with WARN_T=0 → AUTO_OFF.
  - AUTO_WARN: `saida`=blink phase. The phase inverts every BLINK_T ticks. IR=1 → AUTO_ON with reload. `timer` reaching 0 → AUTO_OFF.
  - MAN_OFF / MAN_ON: `saida`=0 / 1. A short press swaps between them. IR is ignored.
  - Mode toggle AUTO→MANUAL: lamp state is kept (AUTO_ON or AUTO_WARN → MAN_ON; AUTO_OFF → MAN_OFF).
  - Mode toggle MANUAL→AUTO: always AUTO_OFF, `timer`=0.
- `all_off`, any cycle, takes priority over tick events in the same cycle:
  - AUTO states → AUTO_OFF with `timer`=0.
  - MAN_ON → MAN_OFF.
  - Mode and debounce state are unchanged.

## Timing
- Reset (`rst`=0 at an edge) clears everything: `saida`=0, `led`=0, `tick`=0, every zone in AUTO_OFF, all counters and `db` at 0, synchronisers at 0. Reset mid-press or mid-warning aborts with no toggle.
- Input-to-sampling latency is 2 `clk` cycles; state changes take effect at the tick edge.
- `saida` and `led` update on the edge after the decision: one `clk` after a tick, or one `clk` after `all_off`.
- Debounced press from a clean edge: DEBOUNCE_P ticks (plus sync latency and up to CLK_DIV cycles of tick alignment).
- Mode toggle: SWITCH_MODE_MIN_T ticks after `db` rises.
- AUTO on-time after IR falls: AUTO_SHUTDOWN_T ticks total, of which the last WARN_T are blinking.
- Zones are fully independent. Simultaneous events in different zones all take effect on the same tick.

## Test plan
Bench parameters: CLK_DIV=4, DEBOUNCE_P=3, SWITCH_MODE_MIN_T=20, AUTO_SHUTDOWN_T=40, WARN_T=10, BLINK_T=2, N_ZONES=4.
- Reset: hold `rst`=0 for 10 cycles with all inputs high → all outputs 0. After release, `tick` pulses every 4 cycles.
- Debounce: zone 0 button glitch lasting 2 ticks → `db` stays 0. A 3-tick hold → `db`=1. A 30-tick hold → `led[0]`=1 after exactly 20 ticks and no lamp toggle on release.
- AUTO cycle: IR[1] pulse lasting 1 tick → `saida[1]`=1 for 30 ticks, then blinks 1,1,0,0,… for 10 ticks, then 0. IR pulse during the blink → solid 1 again with a full reload.
- MANUAL toggle: zone 2 in MANUAL. A 5-tick press toggles `saida[2]` 0→1, the next press 1→0. IR activity has no effect.
- Mode transfer: zone 3 in AUTO_WARN, then long press → `led[3]`=1, `saida[3]`=1 steady. Long press again → `led[3]`=0, `saida[3]`=0.
- `all_off`: zones 0–3 lit (mixed modes); `all_off` pulses for 1 cycle coincident with a tick → every `saida`=0 the next cycle and `led` unchanged.
